// File: rtl/replay_mem_ctrl.sv
// Replay memory controller: circular buffer of transition words in an external
// single-cycle-write, registered-read RAM port, with age-indexed reads (0 = newest).
module replay_mem_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 48
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_valid,
  output logic                  o_rd_ready,
  input  logic [ADDR_WIDTH-1:0] i_rd_idx,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_err,
  input  logic                  i_rd_ready,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_ram_wr_n,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  localparam logic [ADDR_WIDTH:0] CNT_MAX =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_MAX_M1 =
    {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH-1:0] ONE =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_ram_wr_n;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_err;

  logic                  w_idle;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  assign w_idle     = (r_state == S_IDLE);
  assign w_in_range = ({1'b0, i_rd_idx} < r_count);
  // Newest word sits one slot behind the write pointer; wraps naturally.
  assign w_rd_addr  = r_wr_ptr - ONE - i_rd_idx;

  // Push wins over read, so a read is only offered when no push is pending.
  assign o_wr_ready = w_idle & ~i_rst;
  assign o_rd_ready = w_idle & ~i_wr_valid & ~i_rst;

  assign o_count    = r_count;
  assign o_full     = r_full;
  assign o_ram_wr_n = r_ram_wr_n;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_data = r_ram_data;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_rd_err   = r_rd_err;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_wr_valid)
          w_next = S_WRITE;
        else if (i_rd_valid)
          w_next = w_in_range ? S_RD_ISSUE : S_RD_HOLD;
      end
      S_WRITE:    w_next = S_IDLE;
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT:  w_next = S_RD_HOLD;
      S_RD_HOLD:  if (i_rd_ready) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Buffer bookkeeping, RAM port drive and read response registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_ram_wr_n <= 1'b1;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_wr_valid) begin
            r_ram_wr_n <= 1'b0;
            r_ram_addr <= r_wr_ptr;
            r_ram_data <= i_wr_data;
          end else if (i_rd_valid) begin
            if (w_in_range) begin
              r_ram_addr <= w_rd_addr;
            end else begin
              r_rd_valid <= 1'b1;
              r_rd_err   <= 1'b1;
              r_rd_data  <= '0;
            end
          end
        end
        S_WRITE: begin
          r_ram_wr_n <= 1'b1;
          r_wr_ptr   <= r_wr_ptr + ONE;
          if (r_count != CNT_MAX)
            r_count <= r_count + 1'b1;
          if (r_count == CNT_MAX_M1)
            r_full <= 1'b1;
        end
        S_RD_ISSUE: begin
          r_ram_wr_n <= 1'b1;
        end
        S_RD_WAIT: begin
          r_rd_data  <= i_ram_data;
          r_rd_valid <= 1'b1;
          r_rd_err   <= 1'b0;
        end
        S_RD_HOLD: begin
          if (i_rd_ready)
            r_rd_valid <= 1'b0;
        end
        default: begin
          r_ram_wr_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_replay_mem_ctrl.sv
// Bench for replay_mem_ctrl at depth 8: queue model of pushed words,
// behavioural RAM, per-cycle compare plus literal pins.
module tb_replay_mem_ctrl;

  localparam int AW = 3;
  localparam int DW = 48;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_wr_valid = 1'b0;
  logic          o_wr_ready;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_rd_valid = 1'b0;
  logic          o_rd_ready;
  logic [AW-1:0] i_rd_idx = '0;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_err;
  logic          i_rd_ready = 1'b0;
  logic [AW:0]   o_count;
  logic          o_full;
  logic          o_ram_wr_n;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_data;
  logic [DW-1:0] ram_q;

  replay_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_data(i_wr_data),
    .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready),
    .i_rd_idx(i_rd_idx),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_rd_err(o_rd_err), .i_rd_ready(i_rd_ready),
    .o_count(o_count), .o_full(o_full),
    .o_ram_wr_n(o_ram_wr_n), .o_ram_addr(o_ram_addr),
    .o_ram_data(o_ram_data), .i_ram_data(ram_q)
  );

  always #5 clk = ~clk;

  // RAM: write on strobe, read data registered one clock after address.
  logic [DW-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (!o_ram_wr_n) ram[o_ram_addr] <= o_ram_data;
    ram_q <= ram[o_ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state.
  logic [DW-1:0] hist[$];
  int            m_wptr = 0;
  int            exp_strobes = 0;
  int            wr_strobes = 0;
  logic [AW-1:0] e_waddr = '0;
  logic [DW-1:0] e_wdata = '0;
  logic [DW-1:0] e_rd_data = '0;
  logic          e_rd_err = 1'b0;
  bit            e_rd_armed = 0;
  bit            quiet = 0;

  function automatic int m_count();
    return (hist.size() > DEPTH) ? DEPTH : hist.size();
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (!o_ram_wr_n) begin
        wr_strobes++;
        chk("wr_addr", 64'(o_ram_addr), 64'(e_waddr));
        chk("wr_data", 64'(o_ram_data), 64'(e_wdata));
      end
      if (o_rd_valid) begin
        if (!e_rd_armed) begin
          chk("rd_unexpected", 64'(o_rd_valid), 64'(0));
        end else begin
          chk("rd_data", 64'(o_rd_data), 64'(e_rd_data));
          chk("rd_err", 64'(o_rd_err), 64'(e_rd_err));
        end
      end
      if (quiet) begin
        chk("count", 64'(o_count), 64'(m_count()));
        chk("full", 64'(o_full), 64'(m_count() == DEPTH));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_n"}, 64'(o_ram_wr_n), 64'(1));
    chk({tag, "_addr"}, 64'(o_ram_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(o_ram_data), 64'(0));
    chk({tag, "_rvalid"}, 64'(o_rd_valid), 64'(0));
    chk({tag, "_rdata"}, 64'(o_rd_data), 64'(0));
    chk({tag, "_rerr"}, 64'(o_rd_err), 64'(0));
    chk({tag, "_count"}, 64'(o_count), 64'(0));
    chk({tag, "_full"}, 64'(o_full), 64'(0));
    chk({tag, "_wrdy"}, 64'(o_wr_ready), 64'(0));
  endtask

  task automatic model_push(input logic [DW-1:0] d);
    hist.push_back(d);
    m_wptr = (m_wptr + 1) % DEPTH;
    exp_strobes++;
  endtask

  task automatic model_read(input int idx);
    int n;
    n = hist.size();
    if (idx < m_count()) begin
      e_rd_data = hist[n - 1 - idx];
      e_rd_err  = 1'b0;
    end else begin
      e_rd_data = '0;
      e_rd_err  = 1'b1;
    end
    e_rd_armed = 1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    bit ok;
    quiet = 0;
    @(negedge clk);
    i_wr_valid = 1'b1;
    i_wr_data  = d;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      if (o_wr_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("wr_timeout", 64'(0), 64'(1));
    e_waddr = AW'(m_wptr);
    e_wdata = d;
    @(posedge clk); #1;
    i_wr_valid = 1'b0;
    model_push(d);
    @(negedge clk);
    @(negedge clk);
    quiet = 1;
  endtask

  // Wait for the response after an accept edge, optionally stall, then consume.
  task automatic rd_tail(input logic [AW-1:0] a0, input int hold,
                         output logic [DW-1:0] got);
    int lat;
    lat = 0;
    got = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (o_rd_valid) begin lat = k; break; end
    end
    chk("rd_latency", 64'(lat), e_rd_err ? 64'(1) : 64'(3));
    if (e_rd_err) chk("err_no_ram", 64'(o_ram_addr), 64'(a0));
    got = o_rd_data;
    for (int k = 0; k < hold; k++) begin
      chk("hold_wrdy", 64'(o_wr_ready), 64'(0));
      chk("hold_valid", 64'(o_rd_valid), 64'(1));
      @(negedge clk);
    end
    i_rd_ready = 1'b1;
    @(posedge clk); #1;
    i_rd_ready = 1'b0;
    e_rd_armed = 0;
    @(negedge clk);
    chk("rd_drop", 64'(o_rd_valid), 64'(0));
    quiet = 1;
  endtask

  task automatic rd(input int idx, input int hold,
                    output logic [DW-1:0] got);
    bit ok;
    logic [AW-1:0] a0;
    quiet = 0;
    model_read(idx);
    @(negedge clk);
    i_rd_valid = 1'b1;
    i_rd_idx   = AW'(idx);
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      if (o_rd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("rd_timeout", 64'(0), 64'(1));
    a0 = o_ram_addr;
    @(posedge clk); #1;
    i_rd_valid = 1'b0;
    rd_tail(a0, hold, got);
  endtask

  logic [DW-1:0] got;
  int            gap;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    #1;
    chk("wrdy_after_rst", 64'(o_wr_ready), 64'(1));
    quiet = 1;

    // Three pushes.
    push(48'h1);
    push(48'h2);
    push(48'h3);
    chk("count3", 64'(o_count), 64'(3));
    chk("ram0", 64'(ram[0]), 64'(1));
    chk("ram1", 64'(ram[1]), 64'(2));
    chk("ram2", 64'(ram[2]), 64'(3));

    // Reads, in range and out of range.
    rd(0, 0, got); chk("lit_idx0", 64'(got), 64'(3));
    rd(2, 0, got); chk("lit_idx2", 64'(got), 64'(1));
    rd(3, 0, got); chk("lit_idx3", 64'(got), 64'(0));

    // Fill past depth: 10 pushes total, pointer wraps to 2.
    for (int v = 4; v <= 10; v++) push(DW'(v));
    chk("count_full", 64'(o_count), 64'(8));
    chk("full_flag", 64'(o_full), 64'(1));
    chk("ram1_wrap", 64'(ram[1]), 64'(10));
    rd(0, 0, got); chk("lit_w_idx0", 64'(got), 64'(10));
    rd(7, 0, got); chk("lit_w_idx7", 64'(got), 64'(3));
    rd(5, 0, got); chk("lit_w_idx5", 64'(got), 64'(5));
    push(48'hABCD_0000_1234);
    chk("count_sat", 64'(o_count), 64'(8));

    // Simultaneous push and read: push wins, read follows two cycles later.
    quiet = 0;
    @(negedge clk);
    i_wr_valid = 1'b1;
    i_wr_data  = 48'h11;
    i_rd_valid = 1'b1;
    i_rd_idx   = '0;
    #1;
    chk("both_wrdy", 64'(o_wr_ready), 64'(1));
    chk("both_rrdy", 64'(o_rd_ready), 64'(0));
    e_waddr = AW'(m_wptr);
    e_wdata = 48'h11;
    @(posedge clk); #1;
    i_wr_valid = 1'b0;
    model_push(48'h11);
    model_read(0);
    gap = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (o_rd_ready) begin gap = k; break; end
    end
    chk("rd_after_push_gap", 64'(gap), 64'(2));
    @(posedge clk); #1;
    i_rd_valid = 1'b0;
    rd_tail(o_ram_addr, 0, got);
    chk("lit_same_cycle", 64'(got), 64'(48'h11));

    // Stall the response for five cycles.
    rd(1, 5, got);
    chk("lit_hold", 64'(got), 64'(48'hABCD_0000_1234));

    // Reset during WRITE.
    quiet = 0;
    @(negedge clk);
    i_wr_valid = 1'b1;
    i_wr_data  = 48'h77;
    @(posedge clk); #1;
    rst = 1'b1;
    i_wr_valid = 1'b0;
    #1;
    chk_reset_outputs("rst_wr");
    hist.delete();
    m_wptr = 0;
    @(negedge clk); #1;
    rst = 1'b0;
    quiet = 1;
    push(48'h55);
    chk("ram0_after_rst", 64'(ram[0]), 64'(48'h55));
    rd(0, 0, got); chk("lit_after_rst", 64'(got), 64'(48'h55));

    // Reset during RD_WAIT.
    quiet = 0;
    model_read(0);
    @(negedge clk);
    i_rd_valid = 1'b1;
    i_rd_idx   = '0;
    @(posedge clk); #1;
    i_rd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_rd");
    e_rd_armed = 0;
    hist.delete();
    m_wptr = 0;
    @(negedge clk); #1;
    rst = 1'b0;
    quiet = 1;
    push(48'h66);
    chk("ram0_after_rst2", 64'(ram[0]), 64'(48'h66));
    chk("count_after_rst2", 64'(o_count), 64'(1));

    repeat (2) @(negedge clk);
    chk("strobe_count", 64'(wr_strobes), 64'(exp_strobes));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
